// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the 4-bit CPU control sequencer: opcodes, ALU codes,
// state encoding and the opcode decoder.
package cpu_ctrl_pkg;

  localparam int IW_DEF      = 8;
  localparam int AW_DEF      = 4;
  localparam int TIMEOUT_DEF = 15;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_LDI = 4'h3;
  localparam logic [3:0] OP_LD  = 4'h4;
  localparam logic [3:0] OP_ST  = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JZ  = 4'h7;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [1:0] ALU_IMM = 2'b00;
  localparam logic [1:0] ALU_ADD = 2'b01;
  localparam logic [1:0] ALU_SUB = 2'b10;
  localparam logic [1:0] ALU_MEM = 2'b11;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXEC    = 3'd2,
    S_MEMWAIT = 3'd3,
    S_ADVANCE = 3'd4,
    S_HALT    = 3'd5,
    S_FAULT   = 3'd6
  } state_t;

  // Decoded instruction class, registered once in DECODE.
  typedef struct packed {
    logic       alu;
    logic [1:0] alu_op;
    logic       mem;
    logic       we;
    logic       ld;
    logic       jmp;
    logic       jz;
    logic       hlt;
  } dec_t;

  // Opcodes 8..E are not defined and fall through as NOP.
  function automatic dec_t decode_op(input logic [3:0] op);
    dec_t d;
    d = '0;
    case (op)
      OP_NOP: ;
      OP_ADD: begin d.alu = 1'b1; d.alu_op = ALU_ADD; end
      OP_SUB: begin d.alu = 1'b1; d.alu_op = ALU_SUB; end
      OP_LDI: begin d.alu = 1'b1; d.alu_op = ALU_IMM; end
      OP_LD:  begin d.mem = 1'b1; d.ld = 1'b1; end
      OP_ST:  begin d.mem = 1'b1; d.we = 1'b1; end
      OP_JMP: d.jmp = 1'b1;
      OP_JZ:  d.jz  = 1'b1;
      OP_HLT: d.hlt = 1'b1;
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/cpu_ctrl_fsm_wait_timer.sv
// Watchdog counter shared by the instruction-fetch and data-memory waits.
// expired is high during the waiting cycle whose increment would bring the
// count to TIMEOUT; a valid seen in that same cycle still wins.
module ctrl_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int             CW   = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  // Count waiting cycles; clear on entry to a wait state, hold once expired.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control sequencer: fetch, decode, execute, optional data
// memory wait, PC advance. HALT waits for resume; FAULT is left only by rst.
module cpu_ctrl_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int IW      = IW_DEF,
  parameter int AW      = AW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  output logic          imem_req,
  input  logic          imem_valid,
  input  logic [IW-1:0] instr,
  output logic          dmem_req,
  output logic          dmem_we,
  input  logic          dmem_valid,
  output logic [AW-1:0] dmem_addr,
  input  logic          zero_flag,
  output logic [1:0]    alu_op,
  output logic          acc_we,
  output logic          pc_en,
  output logic          jmp,
  output logic [AW-1:0] offset,
  input  logic          resume,
  output logic          halted,
  output logic          fault,
  output logic [2:0]    state_dbg
);

  localparam int OW = IW - 4;

  state_t        state, state_nxt;
  logic [IW-1:0] ir_p0;
  dec_t          dec_p1;
  logic [OW-1:0] opnd_p1;
  logic          wait_clr, wait_en, wait_expired;

  // State register, instruction register (FETCH) and decoded controls (DECODE).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_FETCH;
      ir_p0   <= '0;
      dec_p1  <= '0;
      opnd_p1 <= '0;
    end else begin
      state <= state_nxt;
      // fetch -> decode boundary
      if (state == S_FETCH && imem_valid) begin
        ir_p0 <= instr;
      end
      // decode -> execute boundary
      if (state == S_DECODE) begin
        dec_p1  <= decode_op(ir_p0[IW-1:IW-4]);
        opnd_p1 <= ir_p0[OW-1:0];
      end
    end
  end

  // Next-state and strobe decode; every output is zero unless its state drives it.
  always_comb begin
    state_nxt = state;
    wait_en   = 1'b0;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    dmem_addr = '0;
    alu_op    = ALU_IMM;
    acc_we    = 1'b0;
    pc_en     = 1'b0;
    jmp       = 1'b0;
    offset    = '0;
    halted    = 1'b0;
    fault     = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_valid) begin
          state_nxt = S_DECODE;
        end else begin
          wait_en = 1'b1;
          if (wait_expired) state_nxt = S_FAULT;
        end
      end
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC: begin
        if (dec_p1.alu) begin
          alu_op    = dec_p1.alu_op;
          acc_we    = 1'b1;
          state_nxt = S_ADVANCE;
        end else if (dec_p1.mem) begin
          dmem_req  = 1'b1;
          dmem_we   = dec_p1.we;
          dmem_addr = AW'(opnd_p1);
          state_nxt = S_MEMWAIT;
        end else if (dec_p1.hlt) begin
          state_nxt = S_HALT;
        end else begin
          state_nxt = S_ADVANCE;
        end
      end
      S_MEMWAIT: begin
        dmem_req  = 1'b1;
        dmem_we   = dec_p1.we;
        dmem_addr = AW'(opnd_p1);
        if (dmem_valid) begin
          if (dec_p1.ld) begin
            alu_op = ALU_MEM;
            acc_we = 1'b1;
          end
          state_nxt = S_ADVANCE;
        end else begin
          wait_en = 1'b1;
          if (wait_expired) state_nxt = S_FAULT;
        end
      end
      S_ADVANCE: begin
        pc_en = 1'b1;
        if (dec_p1.jmp || (dec_p1.jz && zero_flag)) begin
          jmp    = 1'b1;
          offset = AW'(opnd_p1);
        end
        state_nxt = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
        if (resume) state_nxt = S_ADVANCE;
      end
      S_FAULT: fault = 1'b1;
      default: state_nxt = S_FETCH;
    endcase
  end

  // Restart the watchdog whenever a wait state is freshly entered.
  assign wait_clr  = (state_nxt != state) &&
                     (state_nxt == S_FETCH || state_nxt == S_MEMWAIT);
  assign state_dbg = state;

  ctrl_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (wait_clr),
    .en      (wait_en),
    .expired (wait_expired)
  );

endmodule
